// File: rtl/spi_flash_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_bridge_pkg
// Brief    : Shared types and constants for the SPI flash CPU bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
package flash_bridge_pkg;

    localparam int TIMEOUT_W = 12;
    localparam int CE_CNT_W  = 4;

    localparam logic [7:0] FLASH_ERR_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        STROBE     = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        RELEASE    = 3'd4
    } bridge_state_t;

    function automatic logic window_hit(
        input logic [15:0] addr,
        input logic [15:0] base,
        input logic [15:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_window_decode.sv
`default_nettype none
// ============================================================================
// Module   : flash_window_decode
// Brief    : Combinational flash address window hit from base and mask.
// Revision : 1.0 - initial release
// ============================================================================
module flash_window_decode
    import flash_bridge_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h3000,
    parameter logic [15:0] MASK = 16'hF000
) (
    input  logic [15:0] addr,
    output logic        hit
);

    assign hit = window_hit(addr, BASE, MASK);

endmodule
`default_nettype wire

// File: rtl/spi_flash_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_bus_bridge
// Brief    : 6809-bus front end for spi_flash_controller: window decode, ce
//            strobe, CPU halt until ready, read-data latch, timeout recovery.
//            Optional one-entry read cache: define FLASH_READ_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_bus_bridge
    import flash_bridge_pkg::*;
#(
    parameter logic [15:0] FLASH_BASE     = 16'h3000,
    parameter logic [15:0] FLASH_MASK     = 16'hF000,
    parameter int          CE_CYCLES      = 2,
    parameter int          TIMEOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DataBus,
    input  logic        i_RW,
    input  logic [7:0]  i_spi_data,
    input  logic        i_MemoryReady,
    output logic        o_spi_ce,
    output logic [15:0] o_flash_addr,
    output logic [7:0]  o_flash_data,
    output logic        o_flash_rw,
    output logic        o_HALT,
    output logic [7:0]  o_DATA,
    output logic        o_flash_sel,
    output logic        o_timeout
);

    localparam logic [CE_CNT_W-1:0]  CE_LAST   = CE_CNT_W'(CE_CYCLES);
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t        state;
    logic                 enable_q;
    logic [CE_CNT_W-1:0]  ce_cnt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 hit;
    logic                 accept;
    logic                 wait_expired;
    logic                 cache_hit;
    logic [7:0]           cache_byte_out;

    flash_window_decode #(
        .BASE (FLASH_BASE),
        .MASK (FLASH_MASK)
    ) u_decode (
        .addr (i_ADDRESS_BUS),
        .hit  (hit)
    );

    assign o_flash_sel  = hit;
    assign accept       = (state == IDLE) && i_enable && !enable_q && hit;
    assign wait_expired = (wait_cnt == WAIT_LAST);

`ifdef FLASH_READ_CACHE_EN
    logic        cache_valid;
    logic [15:0] cache_addr;
    logic [7:0]  cache_byte;
    logic        read_done;
    logic        abort;

    assign cache_hit      = cache_valid && i_RW && (cache_addr == i_ADDRESS_BUS);
    assign cache_byte_out = cache_byte;
    assign read_done      = (state == WAIT_DONE) && i_MemoryReady && o_flash_rw;
    assign abort          = wait_expired &&
                            (((state == WAIT_START) && i_MemoryReady) ||
                             ((state == WAIT_DONE) && !i_MemoryReady));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_valid <= 1'b0;
            cache_addr  <= 16'h0000;
            cache_byte  <= 8'h00;
        end else if (accept && !i_RW) begin
            cache_valid <= 1'b0;
        end else if (abort) begin
            cache_valid <= 1'b0;
        end else if (read_done) begin
            cache_valid <= 1'b1;
            cache_addr  <= o_flash_addr;
            cache_byte  <= i_spi_data;
        end
    end
`else
    assign cache_hit      = 1'b0;
    assign cache_byte_out = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            enable_q     <= 1'b1;
            ce_cnt       <= '0;
            wait_cnt     <= '0;
            o_spi_ce     <= 1'b0;
            o_HALT       <= 1'b0;
            o_DATA       <= 8'h00;
            o_flash_addr <= 16'h0000;
            o_flash_data <= 8'h00;
            o_flash_rw   <= 1'b1;
            o_timeout    <= 1'b0;
        end else begin
            enable_q <= i_enable;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_flash_addr <= i_ADDRESS_BUS;
                        o_flash_data <= i_DataBus;
                        o_flash_rw   <= i_RW;
                        o_timeout    <= 1'b0;
                        o_HALT       <= 1'b1;
                        ce_cnt       <= '0;
                        wait_cnt     <= '0;
                        if (cache_hit) begin
                            o_DATA <= cache_byte_out;
                            state  <= RELEASE;
                        end else begin
                            state  <= STROBE;
                        end
                    end
                end
                // ce rises on the first STROBE clock and stays up CE_CYCLES clocks
                STROBE: begin
                    if (ce_cnt == CE_LAST) begin
                        o_spi_ce <= 1'b0;
                        ce_cnt   <= '0;
                        state    <= WAIT_START;
                    end else begin
                        o_spi_ce <= 1'b1;
                        ce_cnt   <= ce_cnt + 1'b1;
                    end
                end
                WAIT_START: begin
                    if (!i_MemoryReady) begin
                        wait_cnt <= '0;
                        state    <= WAIT_DONE;
                    end else if (wait_expired) begin
                        o_timeout <= 1'b1;
                        if (o_flash_rw) o_DATA <= FLASH_ERR_BYTE;
                        o_HALT    <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // ready is checked before expiry so a last-clock completion wins
                WAIT_DONE: begin
                    if (i_MemoryReady) begin
                        if (o_flash_rw) o_DATA <= i_spi_data;
                        o_HALT   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= RELEASE;
                    end else if (wait_expired) begin
                        o_timeout <= 1'b1;
                        if (o_flash_rw) o_DATA <= FLASH_ERR_BYTE;
                        o_HALT    <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    o_HALT <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_spi_ce <= 1'b0;
                    o_HALT   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_bus_bridge
// Brief    : Self-checking bench for spi_flash_bus_bridge with a controller
//            model and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_bus_bridge;

    localparam int CE_CYCLES      = 2;
    localparam int TIMEOUT_CYCLES = 4095;
    localparam int MON_LIMIT      = TIMEOUT_CYCLES + 300;
`ifdef FLASH_READ_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        i_enable;
    logic [15:0] i_ADDRESS_BUS;
    logic [7:0]  i_DataBus;
    logic        i_RW;
    logic [7:0]  i_spi_data;
    logic        i_MemoryReady;
    logic        o_spi_ce;
    logic [15:0] o_flash_addr;
    logic [7:0]  o_flash_data;
    logic        o_flash_rw;
    logic        o_HALT;
    logic [7:0]  o_DATA;
    logic        o_flash_sel;
    logic        o_timeout;

    spi_flash_bus_bridge #(
        .FLASH_BASE     (16'h3000),
        .FLASH_MASK     (16'hF000),
        .CE_CYCLES      (CE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (i_enable),
        .i_ADDRESS_BUS (i_ADDRESS_BUS),
        .i_DataBus     (i_DataBus),
        .i_RW          (i_RW),
        .i_spi_data    (i_spi_data),
        .i_MemoryReady (i_MemoryReady),
        .o_spi_ce      (o_spi_ce),
        .o_flash_addr  (o_flash_addr),
        .o_flash_data  (o_flash_data),
        .o_flash_rw    (o_flash_rw),
        .o_HALT        (o_HALT),
        .o_DATA        (o_DATA),
        .o_flash_sel   (o_flash_sel),
        .o_timeout     (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]  m_data;
    logic        m_timeout;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic        m_rw;
    logic        m_cv;
    logic [15:0] m_ca;
    logic [7:0]  m_cb;
    int          exp_halt;
    int          exp_ce;

    // Measurements
    int halt_clks;
    int ce_clks;

    // mode 0: controller drops ready d clocks after ce falls, raises it b clocks later
    // mode 1: controller never drops ready
    task automatic model_access(input logic [15:0] a, input logic [7:0] wd, input logic rw,
                                input int mode, input int d, input int b, input logic [7:0] bv);
        if (a[15:12] != 4'h3) begin
            exp_halt = 0;
            exp_ce   = 0;
            return;
        end
        m_addr    = a;
        m_wdata   = wd;
        m_rw      = rw;
        m_timeout = 1'b0;
        if (CACHE_EN && rw && m_cv && m_ca == a) begin
            exp_halt = 1;
            exp_ce   = 0;
            m_data   = m_cb;
            return;
        end
        if (!rw) m_cv = 1'b0;
        exp_ce = CE_CYCLES;
        if (mode == 1 || b > TIMEOUT_CYCLES) begin
            exp_halt  = (mode == 1) ? 1 + CE_CYCLES + TIMEOUT_CYCLES
                                    : 1 + CE_CYCLES + (d + 1) + TIMEOUT_CYCLES;
            m_timeout = 1'b1;
            if (rw) m_data = 8'hFF;
            m_cv = 1'b0;
        end else begin
            exp_halt = 1 + CE_CYCLES + (d + 1) + b;
            if (rw) begin
                m_data = bv;
                m_cv   = 1'b1;
                m_ca   = a;
                m_cb   = bv;
            end
        end
    endtask

    task automatic controller(input int mode, input int d, input int b, input logic [7:0] bv);
        int n;
        if (mode == 1) return;
        n = 0;
        while (o_spi_ce !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) return;
        n = 0;
        while (o_spi_ce !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (d) @(negedge clk);
        i_MemoryReady = 1'b0;
        repeat (b) @(negedge clk);
        i_spi_data    = bv;
        i_MemoryReady = 1'b1;
    endtask

    task automatic run_access(input logic [15:0] a, input logic [7:0] wd, input logic rw,
                              input int mode, input int d, input int b, input logic [7:0] bv);
        logic seen;
        seen      = 1'b0;
        halt_clks = 0;
        ce_clks   = 0;
        @(negedge clk);
        i_ADDRESS_BUS = a;
        i_DataBus     = wd;
        i_RW          = rw;
        i_enable      = 1'b1;
        fork
            controller(mode, d, b, bv);
            begin
                for (int i = 0; i < MON_LIMIT; i++) begin
                    @(negedge clk);
                    if (i == 1) i_enable = 1'b0;
                    if (o_spi_ce === 1'b1) ce_clks++;
                    if (o_HALT === 1'b1) begin
                        halt_clks++;
                        seen = 1'b1;
                    end else if (seen) begin
                        break;
                    end
                    if (!seen && i >= 12) break;
                end
            end
        join
        i_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset         = 1'b0;
        i_enable      = 1'b1;
        i_ADDRESS_BUS = 16'h3AAA;
        i_DataBus     = 8'h00;
        i_RW          = 1'b1;
        i_spi_data    = 8'h00;
        i_MemoryReady = 1'b1;
        m_data = 8'h00; m_timeout = 1'b0; m_addr = 16'h0000; m_wdata = 8'h00;
        m_rw = 1'b1; m_cv = 1'b0; m_ca = 16'h0000; m_cb = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_spi_ce, o_HALT, o_timeout, o_flash_rw} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_flags: got ce/halt/to/rw=%b required 0001",
                     {o_spi_ce, o_HALT, o_timeout, o_flash_rw});
        end
        checks++;
        if ({o_DATA, o_flash_addr, o_flash_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got data=%h addr=%h wdata=%h required all zero",
                     o_DATA, o_flash_addr, o_flash_data);
        end
        // enable held high through reset release must not start an access
        reset     = 1'b1;
        halt_clks = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_HALT === 1'b1 || o_spi_ce === 1'b1) halt_clks++;
        end
        checks++;
        if (halt_clks !== 0) begin
            errors++;
            $display("FAIL reset_no_accept: got %0d busy clocks required 0", halt_clks);
        end
        i_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_basic;
        model_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 80, 8'hFA);
        run_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 80, 8'hFA);
        checks++;
        if (ce_clks !== exp_ce) begin
            errors++; $display("FAIL read_ce_len: got %0d required %0d", ce_clks, exp_ce);
        end
        checks++;
        if (halt_clks !== exp_halt) begin
            errors++; $display("FAIL read_halt_len: got %0d required %0d", halt_clks, exp_halt);
        end
        checks++;
        if (o_flash_addr !== 16'h3AAA || o_flash_rw !== 1'b1) begin
            errors++;
            $display("FAIL read_latch: got addr=%h rw=%b required 3aaa 1", o_flash_addr, o_flash_rw);
        end
        checks++;
        if (o_DATA !== 8'hFA || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL read_data: got data=%h to=%b required fa 0", o_DATA, o_timeout);
        end
    endtask

    task automatic test_write;
        model_access(16'h3000, 8'hAA, 1'b0, 0, 2, 10, 8'h77);
        run_access(16'h3000, 8'hAA, 1'b0, 0, 2, 10, 8'h77);
        checks++;
        if (o_flash_data !== 8'hAA || o_flash_rw !== 1'b0) begin
            errors++;
            $display("FAIL write_latch: got wdata=%h rw=%b required aa 0", o_flash_data, o_flash_rw);
        end
        checks++;
        if (o_DATA !== 8'hFA) begin
            errors++; $display("FAIL write_data_hold: got %h required fa", o_DATA);
        end
        checks++;
        if (halt_clks !== exp_halt) begin
            errors++; $display("FAIL write_halt_len: got %0d required %0d", halt_clks, exp_halt);
        end
    endtask

    task automatic test_window_miss;
        @(negedge clk);
        i_ADDRESS_BUS = 16'h8000;
        #1;
        checks++;
        if (o_flash_sel !== 1'b0) begin
            errors++; $display("FAIL miss_sel: got %b required 0", o_flash_sel);
        end
        i_ADDRESS_BUS = 16'h3000 | 16'($urandom_range(0, 16'h0FFF));
        #1;
        checks++;
        if (o_flash_sel !== 1'b1) begin
            errors++; $display("FAIL hit_sel: got %b required 1", o_flash_sel);
        end
        model_access(16'h8000, 8'h55, 1'b1, 0, 2, 5, 8'h11);
        run_access(16'h8000, 8'h55, 1'b1, 0, 2, 5, 8'h11);
        checks++;
        if (ce_clks !== 0 || halt_clks !== 0) begin
            errors++;
            $display("FAIL miss_no_access: got ce=%0d halt=%0d required 0 0", ce_clks, halt_clks);
        end
        checks++;
        if (o_flash_addr !== m_addr) begin
            errors++; $display("FAIL miss_addr_stable: got %h required %h", o_flash_addr, m_addr);
        end
    endtask

    task automatic test_timeout;
        model_access(16'h3AAA, 8'h00, 1'b1, 1, 0, 0, 8'h00);
        run_access(16'h3AAA, 8'h00, 1'b1, 1, 0, 0, 8'h00);
        checks++;
        if (halt_clks !== exp_halt) begin
            errors++; $display("FAIL to_start_halt_len: got %0d required %0d", halt_clks, exp_halt);
        end
        checks++;
        if (o_timeout !== 1'b1 || o_DATA !== 8'hFF) begin
            errors++;
            $display("FAIL to_start_flag: got to=%b data=%h required 1 ff", o_timeout, o_DATA);
        end
        model_access(16'h9123, 8'h00, 1'b1, 0, 2, 5, 8'h22);
        run_access(16'h9123, 8'h00, 1'b1, 0, 2, 5, 8'h22);
        checks++;
        if (o_timeout !== 1'b1) begin
            errors++; $display("FAIL to_sticky_on_miss: got %b required 1", o_timeout);
        end
        // ready returns on the very last allowed clock: completion, not timeout
        model_access(16'h3123, 8'h00, 1'b1, 0, 2, TIMEOUT_CYCLES, 8'h5A);
        run_access(16'h3123, 8'h00, 1'b1, 0, 2, TIMEOUT_CYCLES, 8'h5A);
        checks++;
        if (o_timeout !== m_timeout || o_DATA !== m_data || halt_clks !== exp_halt) begin
            errors++;
            $display("FAIL to_edge_complete: got to=%b data=%h halt=%0d required %b %h %0d",
                     o_timeout, o_DATA, halt_clks, m_timeout, m_data, exp_halt);
        end
        model_access(16'h3124, 8'h00, 1'b1, 0, 2, TIMEOUT_CYCLES + 1, 8'h5B);
        run_access(16'h3124, 8'h00, 1'b1, 0, 2, TIMEOUT_CYCLES + 1, 8'h5B);
        checks++;
        if (o_timeout !== 1'b1 || o_DATA !== 8'hFF || halt_clks !== exp_halt) begin
            errors++;
            $display("FAIL to_done_abort: got to=%b data=%h halt=%0d required 1 ff %0d",
                     o_timeout, o_DATA, halt_clks, exp_halt);
        end
        model_access(16'h3004, 8'h0F, 1'b0, 0, 1, 4, 8'h00);
        run_access(16'h3004, 8'h0F, 1'b0, 0, 1, 4, 8'h00);
        checks++;
        if (o_timeout !== 1'b0 || o_DATA !== m_data) begin
            errors++;
            $display("FAIL to_cleared: got to=%b data=%h required 0 %h", o_timeout, o_DATA, m_data);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        i_ADDRESS_BUS = 16'h3AAA;
        i_RW          = 1'b1;
        i_enable      = 1'b1;
        fork
            controller(0, 3, 60, 8'h66);
            begin
                @(negedge clk);
                @(negedge clk);
                i_enable = 1'b0;
                repeat (30) @(negedge clk);
                reset = 1'b0;
                #1;
                checks++;
                if (o_HALT !== 1'b0 || o_spi_ce !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_async: got halt=%b ce=%b required 0 0", o_HALT, o_spi_ce);
                end
            end
        join
        m_data = 8'h00; m_timeout = 1'b0; m_addr = 16'h0000; m_rw = 1'b1; m_cv = 1'b0;
        checks++;
        if (o_DATA !== m_data || o_flash_addr !== m_addr || o_flash_rw !== m_rw) begin
            errors++;
            $display("FAIL mid_reset_values: got data=%h addr=%h rw=%b required 00 0000 1",
                     o_DATA, o_flash_addr, o_flash_rw);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 80, 8'hFA);
        run_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 80, 8'hFA);
        checks++;
        if (ce_clks !== exp_ce || halt_clks !== exp_halt || o_DATA !== 8'hFA) begin
            errors++;
            $display("FAIL mid_reset_reread: got ce=%0d halt=%0d data=%h required %0d %0d fa",
                     ce_clks, halt_clks, o_DATA, exp_ce, exp_halt);
        end
    endtask

    task automatic test_cache;
        model_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 20, 8'hFA);
        run_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 20, 8'hFA);
        model_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 20, 8'hC3);
        run_access(16'h3AAA, 8'h00, 1'b1, 0, 3, 20, 8'hC3);
        checks++;
        if (ce_clks !== exp_ce || halt_clks !== exp_halt || o_DATA !== m_data) begin
            errors++;
            $display("FAIL cache_second_read: got ce=%0d halt=%0d data=%h required %0d %0d %h",
                     ce_clks, halt_clks, o_DATA, exp_ce, exp_halt, m_data);
        end
        model_access(16'h3000, 8'h12, 1'b0, 0, 2, 6, 8'h00);
        run_access(16'h3000, 8'h12, 1'b0, 0, 2, 6, 8'h00);
        model_access(16'h3AAA, 8'h00, 1'b1, 0, 2, 9, 8'h3C);
        run_access(16'h3AAA, 8'h00, 1'b1, 0, 2, 9, 8'h3C);
        checks++;
        if (ce_clks !== CE_CYCLES || halt_clks !== exp_halt || o_DATA !== 8'h3C) begin
            errors++;
            $display("FAIL cache_after_write: got ce=%0d halt=%0d data=%h required %0d %0d 3c",
                     ce_clks, halt_clks, o_DATA, CE_CYCLES, exp_halt);
        end
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  bv;
        logic        rw;
        int          d;
        int          b;
        int          sel;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 3);
            a   = 16'($urandom);
            if (sel == 0) a = 16'h3AAA;
            else if (sel == 1) begin
                if (a[15:12] == 4'h3) a[15:12] = 4'h8;
            end else a[15:12] = 4'h3;
            wd = 8'($urandom);
            bv = 8'($urandom);
            rw = 1'($urandom);
            d  = $urandom_range(1, 5);
            b  = $urandom_range(1, 30);
            model_access(a, wd, rw, 0, d, b, bv);
            run_access(a, wd, rw, 0, d, b, bv);
            checks++;
            if (ce_clks !== exp_ce || halt_clks !== exp_halt) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got ce=%0d halt=%0d required %0d %0d",
                         n, ce_clks, halt_clks, exp_ce, exp_halt);
            end
            checks++;
            if (o_DATA !== m_data || o_timeout !== m_timeout) begin
                errors++;
                $display("FAIL rand_data[%0d]: got data=%h to=%b required %h %b",
                         n, o_DATA, o_timeout, m_data, m_timeout);
            end
            checks++;
            if (o_flash_addr !== m_addr || o_flash_rw !== m_rw || o_flash_data !== m_wdata) begin
                errors++;
                $display("FAIL rand_latch[%0d]: got %h/%b/%h required %h/%b/%h", n,
                         o_flash_addr, o_flash_rw, o_flash_data, m_addr, m_rw, m_wdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write();
        test_window_miss();
        test_timeout();
        test_reset_mid();
        test_cache();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_bus_bridge.md
Name: spi_flash_bus_bridge

Overview:
CPU-side front end for spi_flash_controller. Decodes the flash address window on the 6809-style CPU bus and issues a stretched spi_ce strobe with the captured address, data and RW. Holds the CPU with o_HALT until the controller reports ready, then latches the returned byte and presents it on the CPU read path. Adds timeout recovery so that a hung SPI transfer cannot halt the CPU indefinitely.

Parameters:
FLASH_BASE, 16'h3000, window base; hit when (addr & FLASH_MASK) == FLASH_BASE
FLASH_MASK, 16'hF000, window decode mask
CE_CYCLES, 2, clocks spi_ce is held high (1..15)
TIMEOUT_CYCLES, 4095, max clocks in any wait state before abort (fits 12-bit counter)

Ports:
clk  in  1  system clock (88.67 MHz)
reset  in  1  asynchronous active-low reset
i_enable  in  1  CPU bus-cycle qualifier (E); an access starts on its rising edge
i_ADDRESS_BUS  in  16  CPU address
i_DataBus  in  8  CPU write data
i_RW  in  1  1 = read, 0 = write
i_spi_data  in  8  byte returned by the controller (o_spi_data)
i_MemoryReady  in  1  controller ready level (high = idle or done)
o_spi_ce  out  1  transaction strobe to the controller
o_flash_addr  out  16  latched address to the controller
o_flash_data  out  8  latched write data to the controller
o_flash_rw  out  1  latched RW to the controller
o_HALT  out  1  CPU halt request
o_DATA  out  8  read data to the CPU bus mux
o_flash_sel  out  1  window hit, combinational on the current address
o_timeout  out  1  sticky abort flag; cleared by reset or the next accepted access

Behaviour:
- Reset (async, reset = 0):
  - state IDLE.
  - o_spi_ce 0, o_HALT 0, o_DATA 8'h00, o_flash_addr 16'h0000, o_flash_data 8'h00, o_flash_rw 1, o_timeout 0.
  - Counters 0. The registered copy of i_enable resets to 1, so no access is accepted in the first cycle.
- Accept condition: state IDLE, i_enable rising edge (current 1, previous 0), and a window hit.
  - On accept: latch address, data and RW into o_flash_*; clear o_timeout; assert o_HALT on the next clock; go to STROBE.
  - No accept on a window miss or outside IDLE; rising edges in non-IDLE states are ignored.
- STROBE: o_spi_ce = 1 for exactly CE_CYCLES clocks, then o_spi_ce = 0 and go to WAIT_START.
- WAIT_START: wait for i_MemoryReady = 0, meaning the controller has started. Go to WAIT_DONE.
- WAIT_DONE: wait for i_MemoryReady = 1.
  - On a read, capture i_spi_data into o_DATA in that same clock.
  - Go to RELEASE.
- RELEASE: deassert o_HALT for one clock, then return to IDLE. o_DATA holds until the next completed read.
- Write access (o_flash_rw = 0): same sequence. o_DATA is unchanged.
- Timeout:
  - The counter runs in WAIT_START and WAIT_DONE and clears on every state change.
  - On reaching TIMEOUT_CYCLES: set o_timeout. On a read, o_DATA = 8'hFF. Go to RELEASE.
- Latency, read hit with the controller responding: 1 + CE_CYCLES + controller time + 1 clocks from the accept edge to o_HALT = 0.
- Simultaneous events: i_MemoryReady rising in the same clock that the counter expires means completion wins, with no timeout.
- Reset mid-operation: o_spi_ce and o_HALT drop asynchronously and no data is latched.
- o_flash_* stay stable from accept until the next accept.

Optional Feature:
FLASH_READ_CACHE_EN:
- When defined: a one-entry cache holds {valid, addr, byte}.
  - A read accept whose address equals the cached address with valid = 1 skips STROBE and the wait states. It goes straight to RELEASE with o_DATA = cached byte; o_HALT is high for 1 clock only.
  - Completed reads fill the cache.
  - Any write accept in the window, a timeout, or reset clears valid.
- When undefined: every accepted read issues a full SPI transaction, and no cache storage exists.

Decomposition:
- Package flash_bridge_pkg holds:
  - state enum (IDLE, STROBE, WAIT_START, WAIT_DONE, RELEASE)
  - TIMEOUT_W = 12
  - FLASH_ERR_BYTE = 8'hFF
- One natural sub-module, flash_window_decode: combinational hit from address, base and mask. It is reused by the CPU read-data mux.

Test Plan:
- Read 16'h3AAA; the controller model drops ready 3 clocks after ce falls, then raises it 80 clocks later with 8'hFA. Required: o_spi_ce high exactly 2 clocks, o_flash_addr = 3AAA, o_flash_rw = 1, o_HALT high until 1 clock after ready, o_DATA = FA, o_timeout = 0.
- Write 16'h3000 with data 8'hAA. Required: o_flash_data = AA, o_flash_rw = 0, o_DATA unchanged (FA), o_HALT released after ready.
- Access to 16'h8000 (window miss). Required: o_flash_sel = 0, no o_spi_ce, o_HALT stays 0.
- Read 16'h3AAA with a model that never drops ready. Required: abort after 4095 clocks in WAIT_START, o_timeout = 1, o_DATA = FF; the next accepted access clears o_timeout.
- Assert reset during WAIT_DONE. Required: o_HALT and o_spi_ce go to 0 immediately, state IDLE; after release, a new read of 16'h3AAA behaves as in the first scenario.
- With FLASH_READ_CACHE_EN defined: read 3AAA twice. The second read issues no o_spi_ce, o_HALT is high 1 clock and o_DATA = FA. Then write 3000 and reread 3AAA; this time a full SPI transaction is issued.
